// File: rtl/dual_rail_decoder.sv
// dual_rail_decoder: receive end of a dual-rail (true/complement) datapath.
// Enforces spacer -> monotonic evaluate -> complete codeword, hands the
// decoded word to single-rail logic through a valid/ready output slot and
// reports protocol violations as one-cycle error pulses plus a saturating count.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   din_t, din_f   true / false rail per bit (00 spacer, 10 one, 01 zero, 11 illegal)
//   dout           decoded data captured from din_t
//   dout_valid     dout holds an unconsumed codeword
//   dout_ready     consumer accepts dout while dout_valid=1
//   err_illegal    pulse: some pair was 11
//   err_glitch     pulse: resolved pair fell back or flipped polarity
//   err_timeout    pulse: evaluation took TIMEOUT cycles without completing
//   err_overflow   pulse: codeword completed while the output slot was full
//   err_count      saturating count of all error pulses
//   err_clr        synchronous clear of err_count
module dual_rail_decoder #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_t,
  input  logic [WIDTH-1:0] din_f,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             err_illegal,
  output logic             err_glitch,
  output logic             err_timeout,
  output logic             err_overflow,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SW = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEEK = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    tcnt, tcnt_nxt;
  logic [WIDTH-1:0] hist_v, hist_v_nxt;
  logic [WIDTH-1:0] hist_t, hist_t_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             valid_nxt;
  logic             ill_nxt, gl_nxt, to_nxt, ov_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Per-pair classification of the current input
  logic [WIDTH-1:0] res_c;
  logic             any_ill_c, all_spacer_c, complete_c;
  logic             eval_glitch_c, hold_glitch_c, slot_free_c;

  assign res_c        = din_t ^ din_f;
  assign any_ill_c    = |(din_t & din_f);
  assign all_spacer_c = ~|(din_t | din_f);
  assign complete_c   = &res_c;
  // A pair resolved earlier in this evaluation must keep the same polarity
  assign eval_glitch_c = |(hist_v & ~(res_c & ~(din_t ^ hist_t)));
  // While holding, pairs may drop to spacer but never show the other polarity
  assign hold_glitch_c = |(res_c & (din_t ^ hist_t));
  assign slot_free_c   = ~dout_valid | dout_ready;

  // State register and all output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SEEK;
      tcnt         <= '0;
      hist_v       <= '0;
      hist_t       <= '0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      err_illegal  <= 1'b0;
      err_glitch   <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
      err_count    <= '0;
    end else begin
      state        <= state_nxt;
      tcnt         <= tcnt_nxt;
      hist_v       <= hist_v_nxt;
      hist_t       <= hist_t_nxt;
      dout         <= dout_nxt;
      dout_valid   <= valid_nxt;
      err_illegal  <= ill_nxt;
      err_glitch   <= gl_nxt;
      err_timeout  <= to_nxt;
      err_overflow <= ov_nxt;
      err_count    <= cnt_nxt;
    end
  end

  // Next-state, capture and error detection
  always_comb begin
    logic       capture;
    logic [2:0] n_err;
    logic [SW-1:0] sum;

    state_nxt  = state;
    tcnt_nxt   = tcnt;
    hist_v_nxt = hist_v;
    hist_t_nxt = hist_t;
    dout_nxt   = dout;
    valid_nxt  = dout_valid;
    ill_nxt    = 1'b0;
    gl_nxt     = 1'b0;
    to_nxt     = 1'b0;
    ov_nxt     = 1'b0;
    capture    = 1'b0;
    n_err      = '0;
    sum        = '0;

    case (state)
      SEEK: begin
        if (all_spacer_c) begin
          state_nxt  = EVAL;
          tcnt_nxt   = '0;
          hist_v_nxt = '0;
          hist_t_nxt = '0;
        end
      end
      EVAL: begin
        if (any_ill_c) begin
          ill_nxt   = 1'b1;
          state_nxt = SEEK;
        end else if (eval_glitch_c) begin
          gl_nxt    = 1'b1;
          state_nxt = SEEK;
        end else if (complete_c) begin
          capture    = 1'b1;
          state_nxt  = HOLD;
          hist_v_nxt = '1;
          hist_t_nxt = din_t;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          to_nxt    = 1'b1;
          state_nxt = SEEK;
        end else begin
          tcnt_nxt   = tcnt + TW'(1);
          hist_v_nxt = res_c;
          hist_t_nxt = din_t;
        end
      end
      HOLD: begin
        if (any_ill_c) begin
          ill_nxt   = 1'b1;
          state_nxt = SEEK;
        end else if (hold_glitch_c) begin
          gl_nxt    = 1'b1;
          state_nxt = SEEK;
        end else if (all_spacer_c) begin
          state_nxt  = EVAL;
          tcnt_nxt   = '0;
          hist_v_nxt = '0;
          hist_t_nxt = '0;
        end
      end
      default: state_nxt = SEEK;
    endcase

    // Output slot: a capture into a full slot is dropped and flagged
    if (capture) begin
      if (slot_free_c) begin
        dout_nxt  = din_t;
        valid_nxt = 1'b1;
      end else begin
        ov_nxt = 1'b1;
      end
    end else if (dout_valid && dout_ready) begin
      valid_nxt = 1'b0;
    end

    // Count tracks the pulses being registered this edge
    n_err = 3'(ill_nxt) + 3'(gl_nxt) + 3'(to_nxt) + 3'(ov_nxt);
    sum   = (err_clr ? '0 : SW'(err_count)) + SW'(n_err);
    if (sum > SW'(CNT_MAX)) begin
      cnt_nxt = CNT_MAX;
    end else begin
      cnt_nxt = sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_dual_rail_decoder.sv
// Bench for dual_rail_decoder: directed vector table, hand sequences for
// saturation and asynchronous reset, then random traffic against a model.
module tb_dual_rail_decoder;

  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] din_t, din_f;
  logic         dout_ready, err_clr;
  logic [W-1:0] dout, dout2;
  logic         dout_valid, dout_valid2;
  logic         err_illegal, err_glitch, err_timeout, err_overflow;
  logic         e_ill2, e_gl2, e_to2, e_ov2;
  logic [7:0]   err_count;
  logic [1:0]   err_count2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dual_rail_decoder #(.WIDTH(W), .TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din_t(din_t), .din_f(din_f),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .err_illegal(err_illegal), .err_glitch(err_glitch),
    .err_timeout(err_timeout), .err_overflow(err_overflow),
    .err_count(err_count), .err_clr(err_clr)
  );

  dual_rail_decoder #(.WIDTH(W), .TIMEOUT(15), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .din_t(din_t), .din_f(din_f),
    .dout(dout2), .dout_valid(dout_valid2), .dout_ready(dout_ready),
    .err_illegal(e_ill2), .err_glitch(e_gl2),
    .err_timeout(e_to2), .err_overflow(e_ov2),
    .err_count(err_count2), .err_clr(err_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({dout, dout_valid, err_illegal, err_glitch, err_timeout,
                err_overflow, err_count, err_count2});
  endfunction

  task automatic step(input logic [W-1:0] t, input logic [W-1:0] f,
                      input logic rdy, input logic clr);
    @(negedge clk);
    din_t = t; din_f = f; dout_ready = rdy; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [W-1:0] t, f;
    logic         rdy, clr;
    logic [W-1:0] dout;
    logic         v;
    logic [3:0]   errs;   // {illegal, glitch, timeout, overflow}
    logic [7:0]   cnt;
    logic [1:0]   cnt2;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [W-1:0] t, input logic [W-1:0] f, input logic rdy,
                     input logic clr, input logic [W-1:0] d, input logic v,
                     input logic [3:0] e, input logic [7:0] c, input logic [1:0] c2);
    vec_t r;
    r.t = t; r.f = f; r.rdy = rdy; r.clr = clr; r.dout = d; r.v = v;
    r.errs = e; r.cnt = c; r.cnt2 = c2;
    tbl.push_back(r);
  endtask

  // ---------------- behavioural reference model ----------------
  int           m_phase;          // 0 waiting for spacer, 1 evaluating, 2 holding
  bit           m_hv[W];
  bit           m_ht[W];
  int           m_wait;
  logic [W-1:0] m_dout;
  bit           m_valid, m_ill, m_gl, m_to, m_ov;
  int           m_cnt, m_cnt2;

  task automatic m_reset();
    m_phase = 0; m_wait = 0; m_dout = '0; m_valid = 0;
    m_ill = 0; m_gl = 0; m_to = 0; m_ov = 0; m_cnt = 0; m_cnt2 = 0;
    for (int i = 0; i < W; i++) begin m_hv[i] = 0; m_ht[i] = 0; end
  endtask

  task automatic m_start_eval();
    m_phase = 1; m_wait = 0;
    for (int i = 0; i < W; i++) begin m_hv[i] = 0; m_ht[i] = 0; end
  endtask

  task automatic m_step(input logic [W-1:0] t, input logic [W-1:0] f,
                        input bit rdy, input bit clr);
    int nsp = 0, nres = 0, nill = 0, nerr;
    bit glitch = 0, capture = 0;
    for (int i = 0; i < W; i++) begin
      if (t[i] && f[i]) nill++;
      else if (t[i] != f[i]) nres++;
      else nsp++;
    end
    m_ill = 0; m_gl = 0; m_to = 0; m_ov = 0;
    if (m_phase == 0) begin
      if (nsp == W) m_start_eval();
    end else if (m_phase == 1) begin
      for (int i = 0; i < W; i++)
        if (m_hv[i] && !(t[i] != f[i] && t[i] == m_ht[i])) glitch = 1;
      if (nill > 0) begin m_ill = 1; m_phase = 0; end
      else if (glitch) begin m_gl = 1; m_phase = 0; end
      else if (nres == W) begin
        capture = 1; m_phase = 2;
        for (int i = 0; i < W; i++) begin m_hv[i] = 1; m_ht[i] = t[i]; end
      end else begin
        m_wait++;
        if (m_wait >= 15) begin m_to = 1; m_phase = 0; end
        else
          for (int i = 0; i < W; i++)
            if (t[i] != f[i]) begin m_hv[i] = 1; m_ht[i] = t[i]; end
      end
    end else begin
      for (int i = 0; i < W; i++)
        if (t[i] != f[i] && t[i] != m_ht[i]) glitch = 1;
      if (nill > 0) begin m_ill = 1; m_phase = 0; end
      else if (glitch) begin m_gl = 1; m_phase = 0; end
      else if (nsp == W) m_start_eval();
    end
    if (capture) begin
      if (!m_valid || rdy) begin m_dout = t; m_valid = 1; end
      else m_ov = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    nerr = int'(m_ill) + int'(m_gl) + int'(m_to) + int'(m_ov);
    m_cnt  = (clr ? 0 : m_cnt) + nerr;
    m_cnt2 = (clr ? 0 : m_cnt2) + nerr;
    if (m_cnt > 255) m_cnt = 255;
    if (m_cnt2 > 3) m_cnt2 = 3;
  endtask

  function automatic logic [31:0] model_vec();
    return 32'({m_dout, m_valid, m_ill, m_gl, m_to, m_ov, 8'(m_cnt), 2'(m_cnt2)});
  endfunction

  initial begin
    logic [W-1:0] rt, rf, rv;
    logic         rr, rc;

    din_t = '0; din_f = '0; dout_ready = 1'b0; err_clr = 1'b0;

    // Reset values, asserted asynchronously before any clock edge
    #2 rst_n = 1'b0;
    #1 chk("reset_state", dut_vec(), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // spacer, 101 capture, stable output under backpressure, ready pulse
    add(3'b000, 3'b000, 0, 0, 3'b000, 0, 4'b0000, 0, 0);
    add(3'b101, 3'b010, 0, 0, 3'b101, 1, 4'b0000, 0, 0);
    for (int i = 0; i < 5; i++) add(3'b000, 3'b000, 0, 0, 3'b101, 1, 4'b0000, 0, 0);
    add(3'b000, 3'b000, 1, 0, 3'b101, 0, 4'b0000, 0, 0);
    // bits resolve one per cycle to 011, then 100
    add(3'b001, 3'b000, 0, 0, 3'b101, 0, 4'b0000, 0, 0);
    add(3'b011, 3'b000, 0, 0, 3'b101, 0, 4'b0000, 0, 0);
    add(3'b011, 3'b100, 0, 0, 3'b011, 1, 4'b0000, 0, 0);
    add(3'b000, 3'b000, 1, 0, 3'b011, 0, 4'b0000, 0, 0);
    add(3'b100, 3'b011, 0, 0, 3'b100, 1, 4'b0000, 0, 0);
    add(3'b000, 3'b000, 1, 0, 3'b100, 0, 4'b0000, 0, 0);
    // illegal pair, then complete word without spacer is ignored
    add(3'b010, 3'b010, 0, 0, 3'b100, 0, 4'b1000, 1, 1);
    add(3'b101, 3'b010, 0, 0, 3'b100, 0, 4'b0000, 1, 1);
    add(3'b000, 3'b000, 0, 0, 3'b100, 0, 4'b0000, 1, 1);
    // polarity flip on bit0
    add(3'b001, 3'b000, 0, 0, 3'b100, 0, 4'b0000, 1, 1);
    add(3'b000, 3'b001, 0, 0, 3'b100, 0, 4'b0100, 2, 2);
    add(3'b000, 3'b000, 0, 0, 3'b100, 0, 4'b0000, 2, 2);
    // partial word held: timeout on the 15th cycle
    for (int i = 0; i < 14; i++) add(3'b001, 3'b000, 0, 0, 3'b100, 0, 4'b0000, 2, 2);
    add(3'b001, 3'b000, 0, 0, 3'b100, 0, 4'b0010, 3, 3);
    add(3'b000, 3'b000, 0, 0, 3'b100, 0, 4'b0000, 3, 3);
    // overflow with full slot, then capture with ready on the same cycle
    add(3'b001, 3'b110, 0, 0, 3'b001, 1, 4'b0000, 3, 3);
    add(3'b000, 3'b000, 0, 0, 3'b001, 1, 4'b0000, 3, 3);
    add(3'b110, 3'b001, 0, 0, 3'b001, 1, 4'b0001, 4, 3);
    add(3'b000, 3'b000, 0, 0, 3'b001, 1, 4'b0000, 4, 3);
    add(3'b110, 3'b001, 1, 0, 3'b110, 1, 4'b0000, 4, 3);
    add(3'b000, 3'b000, 1, 0, 3'b110, 0, 4'b0000, 4, 3);
    // clear coinciding with an illegal detection, then plain clear
    add(3'b100, 3'b100, 0, 1, 3'b110, 0, 4'b1000, 1, 1);
    add(3'b000, 3'b000, 0, 0, 3'b110, 0, 4'b0000, 1, 1);
    add(3'b000, 3'b000, 0, 1, 3'b110, 0, 4'b0000, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].t, tbl[i].f, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec[%0d]", i), dut_vec(),
          32'({tbl[i].dout, tbl[i].v, tbl[i].errs, tbl[i].cnt, tbl[i].cnt2}));
    end

    // Five illegal events: small counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      step(3'b001, 3'b001, 0, 0);
      chk($sformatf("sat_ill[%0d]", i), 32'(err_illegal), 32'd1);
      chk($sformatf("sat_cnt2[%0d]", i), 32'(err_count2), (i < 3) ? 32'(i + 1) : 32'd3);
      step(3'b000, 3'b000, 0, 0);
    end
    chk("sat_cnt8", 32'(err_count), 32'd5);

    // Capture, let one pair fall in HOLD, then reset asynchronously
    step(3'b010, 3'b101, 0, 0);
    chk("hold_capture", 32'({dout, dout_valid}), 32'({3'b010, 1'b1}));
    step(3'b000, 3'b101, 0, 0);
    chk("hold_partial_fall", 32'({dout, dout_valid, err_illegal, err_glitch}),
        32'({3'b010, 1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    din_t = '0; din_f = '0;
    rst_n = 1'b0;
    #1 chk("async_reset", dut_vec(), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    m_reset();

    // Random traffic against the reference model
    rt = '0; rf = '0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        rt = '0; rf = '0;
      end else if (r < 20) begin
        rv = W'($urandom);
        rt = rv; rf = ~rv;
      end else begin
        for (int b = 0; b < W; b++) begin
          if ($urandom_range(0, 99) < 25) begin
            int k;
            k = int'($urandom_range(0, 30));
            if (k == 0)      begin rt[b] = 1'b1; rf[b] = 1'b1; end
            else if (k < 11) begin rt[b] = 1'b0; rf[b] = 1'b0; end
            else if (k < 21) begin rt[b] = 1'b1; rf[b] = 1'b0; end
            else             begin rt[b] = 1'b0; rf[b] = 1'b1; end
          end
        end
      end
      rr = 1'($urandom_range(0, 1));
      rc = ($urandom_range(0, 63) == 0);
      m_step(rt, rf, rr, rc);
      step(rt, rf, rr, rc);
      chk($sformatf("rnd[%0d]", n), dut_vec(), model_vec());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
